// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, branch condition codes, PC-stage state
// encoding and small decode helpers used by the PC/flag stage.
package cpu_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;
   localparam logic [3:0] OP_LW     = 4'h8;
   localparam logic [3:0] OP_SW     = 4'h9;
   localparam logic [3:0] OP_LLB    = 4'hA;
   localparam logic [3:0] OP_LHB    = 4'hB;
   localparam logic [3:0] OP_B      = 4'hC;
   localparam logic [3:0] OP_BR     = 4'hD;
   localparam logic [3:0] OP_PCS    = 4'hE;
   localparam logic [3:0] OP_HLT    = 4'hF;

   localparam logic [2:0] CC_NE     = 3'b000;
   localparam logic [2:0] CC_EQ     = 3'b001;
   localparam logic [2:0] CC_GT     = 3'b010;
   localparam logic [2:0] CC_LT     = 3'b011;
   localparam logic [2:0] CC_GE     = 3'b100;
   localparam logic [2:0] CC_LE     = 3'b101;
   localparam logic [2:0] CC_OV     = 3'b110;
   localparam logic [2:0] CC_UNCOND = 3'b111;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   // Word-aligned, sign-extended PC-relative displacement.
   function automatic logic [15:0] branch_offset(input logic [8:0] imm);
      return {{6{imm[8]}}, imm, 1'b0};
   endfunction

   function automatic logic writes_zvn(input logic [3:0] op);
      logic res;
      case (op)
         OP_ADD, OP_SUB: res = 1'b1;
         default:        res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic writes_z_only(input logic [3:0] op);
      logic res;
      case (op)
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: res = 1'b1;
         default:                        res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decides whether a condition code holds for the
// given Z/V/N flag values.
module branch_cond
   import cpu_pkg::*;
(
   input  logic [2:0] ccc,
   input  logic       flag_z,
   input  logic       flag_v,
   input  logic       flag_n,
   output logic       taken
);

   // Condition-code decode.
   always_comb begin
      taken = 1'b0;
      case (ccc)
         CC_NE:     taken = ~flag_z;
         CC_EQ:     taken = flag_z;
         CC_GT:     taken = ~flag_z & ~flag_n;
         CC_LT:     taken = flag_n;
         CC_GE:     taken = flag_z | (~flag_z & ~flag_n);
         CC_LE:     taken = flag_n | flag_z;
         CC_OV:     taken = flag_v;
         CC_UNCOND: taken = 1'b1;
         default:   taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_control_chk.sv
// Invariant checker for the PC/flag stage: halt stickiness and hold behaviour.
module pc_control_chk (
   input logic        clk,
   input logic        rst,
   input logic        stall,
   input logic [15:0] pc,
   input logic        flag_z,
   input logic        flag_v,
   input logic        flag_n,
   input logic        branch_taken,
   input logic        halted
);

   a_halt_sticky: assert property (@(posedge clk) disable iff (rst)
      halted |=> halted);

   a_halt_pc_hold: assert property (@(posedge clk) disable iff (rst)
      halted |=> $stable(pc));

   a_stall_pc_hold: assert property (@(posedge clk) disable iff (rst)
      stall |=> $stable(pc));

   a_stall_flag_hold: assert property (@(posedge clk) disable iff (rst)
      stall |=> $stable({flag_z, flag_v, flag_n}));

   a_no_redirect_stalled: assert property (@(posedge clk) disable iff (rst)
      (stall || halted) |-> !branch_taken);

endmodule

// File: rtl/pc_control.sv
// Program-counter and condition-flag stage: PC register, next-PC selection,
// Z/V/N flag register and the RUN/HALT state.
module pc_control
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic [15:0] rs_data,
   input  logic        stall,
   input  logic        alu_z,
   input  logic        alu_v,
   input  logic        alu_n,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2,
   output logic        flag_z,
   output logic        flag_v,
   output logic        flag_n,
   output logic        branch_taken,
   output logic        halted
);

   logic [0:0]  state_r;
   logic [0:0]  state_next_s;
   logic [15:0] pc_r;
   logic [15:0] pc_next_s;
   logic [15:0] seq_pc_s;
   logic        flag_z_r, flag_v_r, flag_n_r;
   logic        flag_z_next_s, flag_v_next_s, flag_n_next_s;
   logic        halted_r;
   logic [3:0]  opcode_s;
   logic        advance_s;
   logic        cond_taken_s;

   assign opcode_s  = instr[15:12];
   assign seq_pc_s  = pc_r + 16'd2;
   assign advance_s = (state_r == ST_RUN) && !stall;

   // Condition is always judged on the registered flags left by the prior instruction.
   branch_cond u_branch_cond (
      .ccc    (instr[11:9]),
      .flag_z (flag_z_r),
      .flag_v (flag_v_r),
      .flag_n (flag_n_r),
      .taken  (cond_taken_s)
   );

   // Redirect indication for the current B/BR instruction.
   always_comb begin
      branch_taken = 1'b0;
      if (advance_s && ((opcode_s == OP_B) || (opcode_s == OP_BR))) begin
         branch_taken = cond_taken_s;
      end else begin
         branch_taken = 1'b0;
      end
   end

   // Next-PC mux; a stalled or halted stage simply holds.
   always_comb begin
      pc_next_s = pc_r;
      if (advance_s) begin
         case (opcode_s)
            OP_B: begin
               if (cond_taken_s) pc_next_s = seq_pc_s + branch_offset(instr[8:0]);
               else              pc_next_s = seq_pc_s;
            end
            OP_BR: begin
               if (cond_taken_s) pc_next_s = rs_data;
               else              pc_next_s = seq_pc_s;
            end
            OP_HLT:  pc_next_s = pc_r;
            default: pc_next_s = seq_pc_s;
         endcase
      end else begin
         pc_next_s = pc_r;
      end
   end

   // Flag update selection by opcode class.
   always_comb begin
      flag_z_next_s = flag_z_r;
      flag_v_next_s = flag_v_r;
      flag_n_next_s = flag_n_r;
      if (advance_s && writes_zvn(opcode_s)) begin
         flag_z_next_s = alu_z;
         flag_v_next_s = alu_v;
         flag_n_next_s = alu_n;
      end else if (advance_s && writes_z_only(opcode_s)) begin
         flag_z_next_s = alu_z;
      end else begin
         flag_z_next_s = flag_z_r;
      end
   end

   // RUN -> HALT once HLT retires; HALT is left only through reset.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (advance_s && (opcode_s == OP_HLT)) state_next_s = ST_HALT;
            else                                   state_next_s = ST_RUN;
         end
         ST_HALT: state_next_s = ST_HALT;
         default: state_next_s = ST_RUN;
      endcase
   end

   // PC register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_r <= RESET_PC;
      else     pc_r <= pc_next_s;
   end

   // Condition flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_z_r <= 1'b0;
         flag_v_r <= 1'b0;
         flag_n_r <= 1'b0;
      end else begin
         flag_z_r <= flag_z_next_s;
         flag_v_r <= flag_v_next_s;
         flag_n_r <= flag_n_next_s;
      end
   end

   // State register and its registered halted indication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_RUN;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         halted_r <= (state_next_s == ST_HALT);
      end
   end

   assign pc       = pc_r;
   assign pc_plus2 = seq_pc_s;
   assign flag_z   = flag_z_r;
   assign flag_v   = flag_v_r;
   assign flag_n   = flag_n_r;
   assign halted   = halted_r;

   pc_control_chk u_chk (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .pc           (pc_r),
      .flag_z       (flag_z_r),
      .flag_v       (flag_v_r),
      .flag_n       (flag_n_r),
      .branch_taken (branch_taken),
      .halted       (halted_r)
   );

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: behavioural reference model with a
// per-cycle compare process, directed literal checks and randomized stimulus.
module tb_pc_control;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic [15:0] rs_data = 16'h0000;
   logic        stall = 1'b0;
   logic        alu_z = 1'b0, alu_v = 1'b0, alu_n = 1'b0;
   logic [15:0] pc, pc_plus2;
   logic        flag_z, flag_v, flag_n, branch_taken, halted;

   logic [2:0]  bc_ccc = 3'b000;
   logic        bc_z = 1'b0, bc_v = 1'b0, bc_n = 1'b0, bc_taken;

   int errors = 0;
   int checks = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   pc_control #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .instr(instr), .rs_data(rs_data), .stall(stall),
      .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
      .pc(pc), .pc_plus2(pc_plus2), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
      .branch_taken(branch_taken), .halted(halted)
   );

   branch_cond u_bc (.ccc(bc_ccc), .flag_z(bc_z), .flag_v(bc_v), .flag_n(bc_n), .taken(bc_taken));

   // Condition table written straight from the mnemonic meanings.
   function automatic logic spec_cond(input logic [2:0] c, input logic z, input logic v, input logic n);
      case (c)
         3'd0:    return !z;
         3'd1:    return z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || (!z && !n);
         3'd5:    return n || z;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [15:0] b_target(input logic [15:0] p, input logic [8:0] imm);
      int off;
      off = int'($signed(imm)) * 2;
      return 16'((int'(p) + 2 + off) & 32'hFFFF);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model state.
   logic [15:0] m_pc;
   logic        m_z, m_v, m_n, m_halted;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc <= 16'h0000; m_z <= 1'b0; m_v <= 1'b0; m_n <= 1'b0; m_halted <= 1'b0;
      end else if (!m_halted && !stall) begin
         if (instr[15:12] == 4'hC)
            m_pc <= spec_cond(instr[11:9], m_z, m_v, m_n) ? b_target(m_pc, instr[8:0]) : m_pc + 16'd2;
         else if (instr[15:12] == 4'hD)
            m_pc <= spec_cond(instr[11:9], m_z, m_v, m_n) ? rs_data : m_pc + 16'd2;
         else if (instr[15:12] == 4'hF)
            m_halted <= 1'b1;
         else
            m_pc <= m_pc + 16'd2;
         if (instr[15:12] inside {4'h0, 4'h1}) begin
            m_z <= alu_z; m_v <= alu_v; m_n <= alu_n;
         end else if (instr[15:12] inside {4'h2, 4'h4, 4'h5, 4'h6}) begin
            m_z <= alu_z;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("pc", pc, m_pc);
         check("pc_plus2", pc_plus2, m_pc + 16'd2);
         check("flags_zvn", {13'd0, flag_z, flag_v, flag_n}, {13'd0, m_z, m_v, m_n});
         check("halted", {15'd0, halted}, {15'd0, m_halted});
         check("branch_taken", {15'd0, branch_taken},
               {15'd0, !m_halted && !stall && (instr[15:12] inside {4'hC, 4'hD}) &&
                       spec_cond(instr[11:9], m_z, m_v, m_n)});
      end
   end

   task automatic drive(input logic [15:0] i, input logic [15:0] r, input logic s,
                        input logic z, input logic v, input logic n);
      instr = i; rs_data = r; stall = s; alu_z = z; alu_v = v; alu_n = n;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [15:0] i, input logic [15:0] r, input logic s,
                       input logic z, input logic v, input logic n);
      drive(i, r, s, z, v, n);
      tick();
   endtask

   // Reset held across one rising edge, released away from any edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      logic [31:0] rnd;
      logic [3:0]  op;
      int          halt_cnt;

      // Standalone condition sweep.
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            bc_ccc = 3'(c); bc_z = f[2]; bc_v = f[1]; bc_n = f[0];
            #1;
            check($sformatf("bc_ccc%0d_zvn%0d", c, f), {15'd0, bc_taken},
                  {15'd0, spec_cond(bc_ccc, bc_z, bc_v, bc_n)});
         end
      end

      rst = 1'b1;
      #1;
      check("reset_pc", pc, 16'h0000);
      check("reset_flags", {13'd0, flag_z, flag_v, flag_n}, 16'h0000);
      check("reset_halted", {15'd0, halted}, 16'h0000);
      cmp_en = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;

      for (int k = 1; k <= 4; k++) begin
         step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("nop_pc%0d", k), pc, 16'(2 * k));
      end
      check("nop_halted", {15'd0, halted}, 16'h0000);
      for (int k = 0; k < 3; k++) step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      check("add_z_pc", pc, 16'h0010);
      check("add_z_flag", {15'd0, flag_z}, 16'h0001);

      drive(16'hC204, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 check("beq_taken", {15'd0, branch_taken}, 16'h0001);
      tick();
      check("beq_pc", pc, 16'h001A);
      step(16'hDE00, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
      check("br_back_pc", pc, 16'h0010);
      drive(16'hC004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 check("bne_not_taken", {15'd0, branch_taken}, 16'h0000);
      tick();
      check("bne_pc", pc, 16'h0012);

      step(16'hDE00, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0);
      step(16'hCFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("b_self_pc", pc, 16'h0020);
      step(16'hDE00, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
      check("br_pc", pc, 16'h1234);
      step(16'hDE00, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      check("wrap_pc_plus2", pc_plus2, 16'h0000);
      step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("wrap_pc", pc, 16'h0000);

      do_reset();
      step(16'h2000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
      check("xor_flags", {13'd0, flag_z, flag_v, flag_n}, 16'h0004);
      step(16'h1000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      check("sub_flags", {13'd0, flag_z, flag_v, flag_n}, 16'h0003);
      drive(16'hCE00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 check("stall_no_taken", {15'd0, branch_taken}, 16'h0000);
      tick();
      check("stall_pc", pc, 16'h0004);

      do_reset();
      for (int k = 0; k < 4; k++) step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         step(16'hF000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
         check($sformatf("hlt_stall_pc%0d", k), pc, 16'h0008);
         check($sformatf("hlt_stall_halted%0d", k), {15'd0, halted}, 16'h0000);
      end
      step(16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hlt_halted", {15'd0, halted}, 16'h0001);
      check("hlt_pc", pc, 16'h0008);
      for (int k = 0; k < 6; k++) begin
         rnd = $urandom();
         step(rnd[15:0], rnd[31:16], rnd[3], rnd[4], rnd[5], rnd[6]);
         check($sformatf("halt_hold_pc%0d", k), pc, 16'h0008);
         check($sformatf("halt_hold_halted%0d", k), {15'd0, halted}, 16'h0001);
      end
      #1 rst = 1'b1;
      #1;
      check("async_rst_pc", pc, 16'h0000);
      check("async_rst_halted", {15'd0, halted}, 16'h0000);
      @(posedge clk);
      #2 rst = 1'b0;

      // Randomized run; the compare process does the checking.
      halt_cnt = 0;
      for (int k = 0; k < 3000; k++) begin
         rnd = $urandom();
         op = rnd[15:12];
         if ((op == 4'hF) && ($urandom_range(0, 7) != 0)) op = 4'h0;
         drive({op, rnd[11:0]}, 16'($urandom()), ($urandom_range(0, 4) == 0),
               rnd[16], rnd[17], rnd[18]);
         tick();
         if (halted) halt_cnt++;
         if ((halt_cnt > 10) || ($urandom_range(0, 299) == 0)) begin
            halt_cnt = 0;
            do_reset();
         end
      end

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_control.md
# pc_control

Program-counter and condition-flag stage that sits directly upstream of instruction fetch in the single-cycle CPU. Holds the PC register, selects the next PC (sequential, PC-relative branch, register branch, halt hold), and owns the Z/V/N flag register written from ALU results. Drives the PC into program memory and supplies PC+2 for the PCS write-back path.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- instr  in  16  current instruction from program memory (opcode = instr[15:12])
- rs_data  in  16  register-file SrcData1, the target for BR
- stall  in  1  holds PC, flags and state for this cycle
- alu_z, alu_v, alu_n  in  1 each  flag results of the current ALU operation
- pc  out  16  current PC, registered
- pc_plus2  out  16  pc + 2, combinational, for PCS write-back
- flag_z, flag_v, flag_n  out  1 each  registered condition flags
- branch_taken  out  1  combinational; current B/BR instruction redirects the PC
- halted  out  1  registered; set once HLT has retired

## Operation
- States: RUN, HALT. Reset -> RUN. RUN + opcode 4'b1111 + !stall -> HALT at the next edge. HALT is sticky until rst.
- Next PC in RUN, !stall:
  - B (4'b1100): taken -> pc + 2 + sext(instr[8:0]) << 1; not taken -> pc + 2.
  - BR (4'b1101): taken -> rs_data; not taken -> pc + 2.
  - HLT (4'b1111): pc unchanged.
  - all others: pc + 2.
- Branch offset: {{6{instr[8]}}, instr[8:0], 1'b0}, summed modulo 2^16. Wrap-around is silent: 16'hFFFE + 2 = 16'h0000.
- Condition code is instr[11:9]:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | (!Z & !N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always
- The condition is evaluated on the registered flags, never on the alu_* inputs.
- Flag writes, when !stall and in RUN:
  - ADD/SUB (0000/0001) load Z, V and N.
  - XOR, SLL, SRA, ROR (0010/0100/0101/0110) load Z only.
  - All other opcodes leave the flags unchanged.
- branch_taken is 0 for non-branch opcodes, and 0 when stall = 1 or in HALT.
- HALT: pc, flags and halted hold regardless of instr or stall.

## Timing
- Reset (asynchronous, immediate): pc = RESET_PC, flag_z/v/n = 0, halted = 0, state = RUN.
- Release of rst takes effect on the next rising edge. rst mid-branch or while halted overrides everything.
- Latency: next PC and flag updates become visible 1 cycle after the instruction is presented. A branch uses the flags set by the previous instruction.
- stall = 1: every register holds for that edge. stall has no effect on the outputs of rst.
- A flag-setting instruction is never a branch, so flag writes and redirects never compete in the same cycle.
- HLT with stall = 1: does not enter HALT until a cycle with stall = 0.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB, OP_LW, OP_SW, OP_LLB, OP_LHB, OP_B, OP_BR, OP_PCS, OP_HLT;
  - condition-code localparams CC_NE through CC_UNCOND;
  - the RUN/HALT state encoding.
- Sub-module branch_cond: combinational; ccc plus the three flags in, taken out. This is the unit-test target.
- Top of pc_control holds the PC register, the flag register, the state register and the next-PC mux.

## Test plan
- Reset then 4 NOPs (ADD, stall = 0): pc = 0, 2, 4, 6, 8; all flags 0; halted = 0.
- ADD with alu_z = 1, then B EQ with offset 9'h004 at pc = 16'h0010: next pc = 16'h001A, branch_taken = 1. The same branch with NE gives 16'h0012.
- B always with offset 9'h1FF at pc = 16'h0020 gives 16'h0020. BR always with rs_data = 16'h1234 gives 16'h1234. At pc = 16'hFFFE a non-branch wraps to 16'h0000.
- XOR with alu_z = 1, alu_n = 1, alu_v = 1 starting from zero flags: only flag_z = 1 afterwards. SUB with n = 1, v = 1, z = 0: flags become z = 0, v = 1, n = 1.
- HLT at pc = 16'h0008 with stall = 1 for 2 cycles, then stall = 0: pc stays 8, halted rises one cycle after stall drops, then stays high under any instr. Asserting rst gives pc = 0 and halted = 0 asynchronously.
- branch_cond sweep: all 8 ccc codes × 8 flag combinations, matched against the Operation equations.
